// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU layer pipeline
package ppu_pkg;

    localparam int         ROW_WIDTH  = 320;
    localparam int         RD_LATENCY = 1;
    localparam logic [7:0] BACKDROP   = 8'h00;

    typedef struct packed {
        logic [3:0] palette;
        logic [3:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        BEHIND = 2'b00,
        MID    = 2'b01,
        FRONT  = 2'b10
    } spr_prio_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MIX,
        S_DRAIN
    } mix_state_t;

    function automatic logic is_opaque(input pixel_t p);
        return p.color != 4'h0;
    endfunction

endpackage

// File: rtl/pixel_priority_resolve.sv
// pixel_priority_resolve: picks the winning layer pixel from bg, fg and sprite
module pixel_priority_resolve
    import ppu_pkg::*;
(
    input  logic [7:0] i_bg,
    input  logic [7:0] i_fg,
    input  logic [7:0] i_spr,
    input  logic [1:0] i_prio,
    output logic [7:0] o_pix
);

    spr_prio_t w_prio;
    logic      w_b;
    logic      w_f;
    logic      w_s;

    assign w_prio = spr_prio_t'(i_prio);
    assign w_b    = is_opaque(i_bg);
    assign w_f    = is_opaque(i_fg);
    assign w_s    = is_opaque(i_spr);

    // Highest-ordered opaque layer wins; FG always covers a BEHIND sprite
    always_comb begin
        o_pix = BACKDROP;
        if (w_prio == BEHIND)
            o_pix = w_f ? i_fg : w_b ? i_bg : w_s ? i_spr : BACKDROP;
        else if (w_prio == MID)
            o_pix = w_f ? i_fg : w_s ? i_spr : w_b ? i_bg : BACKDROP;
        else
            o_pix = w_s ? i_spr : w_f ? i_fg : w_b ? i_bg : BACKDROP;
    end

endmodule

// File: rtl/pixel_mixer.sv
// pixel_mixer: sweeps the three layer engines and writes mixed pixels to the line buffer
module pixel_mixer
    import ppu_pkg::*;
#(
    parameter int ROW_WIDTH = ppu_pkg::ROW_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic       bg_done,
    input  logic       fg_done,
    input  logic       spr_done,
    output logic [8:0] pixel_addr,
    input  logic [7:0] bg_pixel_data,
    input  logic [7:0] fg_pixel_data,
    input  logic [7:0] spr_pixel_data,
    input  logic [1:0] spr_prio,
    output logic [8:0] lb_addr,
    output logic [7:0] lb_data,
    output logic       lb_wren,
    output logic       mix_done,
    output logic       overrun
);

    mix_state_t r_state;
    mix_state_t w_next;
    logic [8:0] r_cnt;
    logic [8:0] r_lb_addr;
    logic       r_wren;
    logic       r_mix_done;
    logic       r_overrun;
    logic       w_last;
    logic       w_all_done;
    logic [7:0] w_mix;

    assign w_last     = r_cnt == 9'(ROW_WIDTH - 1);
    assign w_all_done = bg_done && fg_done && spr_done;

    // Next-state logic for the row sweep
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = line_start ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = w_all_done ? S_MIX : S_WAIT;
            S_MIX:   w_next = w_last ? S_DRAIN : S_MIX;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Sweep counter: cleared on entry to MIX, holds at the last column
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (r_state == S_WAIT && w_all_done)
            r_cnt <= '0;
        else if (r_state == S_MIX && !w_last)
            r_cnt <= r_cnt + 9'd1;
    end

    // Write strobe and address trail the read address by the engines' read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wren     <= 1'b0;
            r_lb_addr  <= '0;
            r_mix_done <= 1'b0;
        end else begin
            r_wren     <= r_state == S_MIX;
            r_lb_addr  <= pixel_addr;
            r_mix_done <= r_state == S_DRAIN;
        end
    end

    // A line_start arriving while a row is still in progress is latched as an overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overrun <= 1'b0;
        else if (line_start && r_state != S_IDLE)
            r_overrun <= 1'b1;
    end

    pixel_priority_resolve u_resolve (
        .i_bg   (bg_pixel_data),
        .i_fg   (fg_pixel_data),
        .i_spr  (spr_pixel_data),
        .i_prio (spr_prio),
        .o_pix  (w_mix)
    );

    assign pixel_addr = (r_state == S_MIX) ? r_cnt : '0;
    assign lb_addr    = r_lb_addr;
    assign lb_wren    = r_wren;
    assign lb_data    = r_wren ? w_mix : BACKDROP;
    assign mix_done   = r_mix_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pixel_mixer.sv
// tb_pixel_mixer: randomized row mixing checked against a layer-order reference model
module tb_pixel_mixer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic       bg_done = 1'b0;
    logic       fg_done = 1'b0;
    logic       spr_done = 1'b0;
    logic [8:0] pixel_addr;
    logic [7:0] bg_pixel_data = 8'h00;
    logic [7:0] fg_pixel_data = 8'h00;
    logic [7:0] spr_pixel_data = 8'h00;
    logic [1:0] spr_prio = 2'b00;
    logic [8:0] lb_addr;
    logic [7:0] lb_data;
    logic       lb_wren;
    logic       mix_done;
    logic       overrun;

    localparam int W = 320;

    logic [7:0] bg_m [512];
    logic [7:0] fg_m [512];
    logic [7:0] sp_m [512];
    logic [1:0] pr_m [512];
    logic [7:0] got  [512];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt, done_cnt, first_wr, done_cyc, l;

    pixel_mixer dut (
        .clk            (clk),
        .rst            (rst),
        .line_start     (line_start),
        .bg_done        (bg_done),
        .fg_done        (fg_done),
        .spr_done       (spr_done),
        .pixel_addr     (pixel_addr),
        .bg_pixel_data  (bg_pixel_data),
        .fg_pixel_data  (fg_pixel_data),
        .spr_pixel_data (spr_pixel_data),
        .spr_prio       (spr_prio),
        .lb_addr        (lb_addr),
        .lb_data        (lb_data),
        .lb_wren        (lb_wren),
        .mix_done       (mix_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine row buffers: one-cycle read latency from the shared address
    always @(posedge clk) begin
        bg_pixel_data  <= bg_m[pixel_addr];
        fg_pixel_data  <= fg_m[pixel_addr];
        spr_pixel_data <= sp_m[pixel_addr];
        spr_prio       <= pr_m[pixel_addr];
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: list layers in priority order, first opaque one wins
    function automatic logic [7:0] ref_pix(input logic [7:0] b, input logic [7:0] f,
                                           input logic [7:0] s, input logic [1:0] p);
        logic [7:0] lay [3];
        if (p[1]) begin
            lay[0] = s; lay[1] = f; lay[2] = b;
        end else if (p[0]) begin
            lay[0] = f; lay[1] = s; lay[2] = b;
        end else begin
            lay[0] = f; lay[1] = b; lay[2] = s;
        end
        for (int i = 0; i < 3; i++)
            if (lay[i][3:0] != 4'h0) return lay[i];
        return 8'h00;
    endfunction

    // Write-side scoreboard sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (lb_wren) begin
                check("lb_addr", lb_addr, wr_cnt);
                check("lb_data", lb_data, ref_pix(bg_m[lb_addr], fg_m[lb_addr], sp_m[lb_addr], pr_m[lb_addr]));
                got[lb_addr] = lb_data;
                if (wr_cnt == 0) first_wr = cyc;
                wr_cnt++;
            end else if (lb_data !== 8'h00) begin
                check("lb_data_idle", lb_data, 0);
            end
            if (mix_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        wr_cnt = 0; done_cnt = 0; first_wr = -1; done_cyc = -1;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 512; i++) begin
            bg_m[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15) << 4) : 8'($urandom);
            fg_m[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15) << 4) : 8'($urandom);
            sp_m[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15) << 4) : 8'($urandom);
            pr_m[i] = 2'($urandom_range(0, 3));
            got[i]  = 8'hxx;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ls();
        @(posedge clk);
        #1;
        line_start = 1'b1;
        l = cyc;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("mix_done_timeout", int'(done_cnt > 0), 1);
    endtask

    initial begin
        fill_rand();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel_addr", pixel_addr, 0);
        check("rst_lb_addr", lb_addr, 0);
        check("rst_lb_wren", lb_wren, 0);
        check("rst_lb_data", lb_data, 0);
        check("rst_mix_done", mix_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Row 1: fast path with directed priority pixels at addresses 0..3
        bg_m[0] = 8'h12; fg_m[0] = 8'h34; sp_m[0] = 8'h56; pr_m[0] = 2'b10;
        bg_m[1] = 8'h12; fg_m[1] = 8'h34; sp_m[1] = 8'h56; pr_m[1] = 2'b00;
        bg_m[2] = 8'h12; fg_m[2] = 8'h30; sp_m[2] = 8'h56; pr_m[2] = 2'b00;
        bg_m[3] = 8'h10; fg_m[3] = 8'h20; sp_m[3] = 8'h30; pr_m[3] = 2'b11;
        bg_done = 1'b1; fg_done = 1'b1; spr_done = 1'b1;
        clear_stats();
        pulse_ls();
        wait_cyc(l + 2);
        check("sweep_addr0", pixel_addr, 0);
        wait_cyc(l + 2 + 150);
        check("sweep_addr150", pixel_addr, 150);
        wait_cyc(l + 2 + 319);
        check("sweep_addr319", pixel_addr, 319);
        wait_done(400);
        @(posedge clk);
        #1;
        check("mix_done_low", mix_done, 0);
        check("r1_first_wr", first_wr, l + 3);
        check("r1_done_cyc", done_cyc, l + 1 + 322);
        check("r1_wr_cnt", wr_cnt, W);
        check("r1_done_cnt", done_cnt, 1);
        check("prio_front", got[0], 8'h56);
        check("prio_behind", got[1], 8'h34);
        check("prio_fg_clear", got[2], 8'h12);
        check("prio_backdrop", got[3], 8'h00);
        check("r1_overrun", overrun, 0);

        // Row 2: staggered engine completion
        fill_rand();
        bg_done = 1'b0; fg_done = 1'b0; spr_done = 1'b0;
        clear_stats();
        pulse_ls();
        wait_cyc(l + 5);   bg_done = 1'b1;
        wait_cyc(l + 40);  fg_done = 1'b1;
        wait_cyc(l + 50);
        check("stag_addr_wait", pixel_addr, 0);
        wait_cyc(l + 100); spr_done = 1'b1;
        wait_cyc(l + 101);
        check("stag_no_wren", wr_cnt, 0);
        wait_done(400);
        check("r2_first_wr", first_wr, l + 102);
        check("r2_done_cyc", done_cyc, l + 100 + 322);
        check("r2_wr_cnt", wr_cnt, W);

        // Row 3: second line_start mid-sweep raises a sticky overrun
        fill_rand();
        clear_stats();
        pulse_ls();
        wait_cyc(l + 100);
        check("ovr_before", overrun, 0);
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        check("ovr_set", overrun, 1);
        wait_done(400);
        repeat (20) @(posedge clk);
        #1;
        check("ovr_sticky", overrun, 1);
        check("ovr_done_cnt", done_cnt, 1);
        check("ovr_wr_cnt", wr_cnt, W);
        check("ovr_idle_addr", pixel_addr, 0);

        // Row 4: asynchronous reset in the middle of a sweep
        fill_rand();
        clear_stats();
        pulse_ls();
        for (int i = 0; i < 400 && pixel_addr != 9'd150; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_reach150", pixel_addr, 150);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wren", lb_wren, 0);
        check("rst_mid_done", mix_done, 0);
        check("rst_mid_addr", pixel_addr, 0);
        check("rst_mid_data", lb_data, 0);
        check("rst_mid_ovr", overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        repeat (10) @(posedge clk);
        #1;
        check("rst_idle_wr", wr_cnt, 0);
        check("rst_idle_done", done_cnt, 0);
        check("rst_idle_addr", pixel_addr, 0);
        pulse_ls();
        wait_done(400);
        check("r4_first_wr", first_wr, l + 3);
        check("r4_done_cyc", done_cyc, l + 1 + 322);
        check("r4_wr_cnt", wr_cnt, W);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
